// File: rtl/bsg_fifo_tx_if.sv
// Register-bus bundle for bsg_fifo_tx: address/data strobes in, registered read data and ack out.
interface bsg_fifo_tx_if;
  logic [7:0] addr;
  logic [7:0] Data_in;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] Data_out;
  logic       ready;

  modport master (output addr, output Data_in, output wr_en, output rd_en,
                  input  Data_out, input ready);
  modport slave  (input  addr, input  Data_in, input  wr_en, input  rd_en,
                  output Data_out, output ready);
endinterface

// File: rtl/bsg_fifo_tx.sv
// Bus-fed TX FIFO driving optionally Gray-encoded symbols on OUT, each held DIV+1 cycles,
// with a drain interrupt and overflow flag.
module bsg_fifo_tx #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned SYM_W = 8
) (
  input  logic             SYS_CLK,
  input  logic             SYS_RST,
  bsg_fifo_tx_if.slave     bus,
  output logic [SYM_W-1:0] OUT,
  output logic             BSG_INT
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [7:0] A_CTRL  = 8'h00;
  localparam logic [7:0] A_DATA  = 8'h01;
  localparam logic [7:0] A_DIV   = 8'h02;
  localparam logic [7:0] A_LEVEL = 8'h03;

  typedef enum logic [0:0] {IDLE, SEND} state_e;

  state_e           state_q, state_d;
  logic             txen_q, txen_d, intmsk_q, intmsk_d, intflag_q, intflag_d;
  logic             gray_q, gray_d, ovf_q, ovf_d, ready_q, ready_d;
  logic [7:0]       div_q, div_d, cnt_q, cnt_d, dout_q, dout_d;
  logic [SYM_W-1:0] out_q, out_d;
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [SYM_W-1:0] mem_q [DEPTH];

  logic       empty_c, full_c, pop_c, push_c, push_ok_c, set_int_c;
  logic       wr_c, rd_c, ctrl_wr_c;
  logic [8:0] level9_c;
  logic [7:0] level_c, ctrl_c;

  function automatic logic [SYM_W-1:0] encode(input logic [SYM_W-1:0] b, input logic g);
    return g ? (b ^ (b >> 1)) : b;
  endfunction

  assign empty_c  = (count_q == '0);
  assign full_c   = (count_q == CW'(DEPTH));
  assign level9_c = 9'(count_q);
  assign level_c  = level9_c[8] ? 8'hFF : level9_c[7:0];
  assign ctrl_c   = {ovf_q, empty_c, full_c, gray_q, (state_q == SEND), intflag_q, intmsk_q, txen_q};

  // Symbol sequencer: pops, holds each symbol DIV+1 cycles, raises drain event.
  always_comb begin
    state_d   = state_q;
    out_d     = out_q;
    cnt_d     = cnt_q;
    pop_c     = 1'b0;
    set_int_c = 1'b0;
    case (state_q)
      IDLE: begin
        out_d = '0;
        if (txen_q && !empty_c) begin
          pop_c   = 1'b1;
          out_d   = encode(mem_q[rptr_q], gray_q);
          cnt_d   = div_q;
          state_d = SEND;
        end
      end
      SEND: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else if (txen_q && !empty_c) begin
          pop_c = 1'b1;
          out_d = encode(mem_q[rptr_q], gray_q);
          cnt_d = div_q;
        end else begin
          state_d   = IDLE;
          out_d     = '0;
          set_int_c = empty_c;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Register bus, FIFO bookkeeping and flag set/clear; a write beats a same-cycle read.
  always_comb begin
    wr_c      = bus.wr_en;
    rd_c      = bus.rd_en & ~bus.wr_en;
    ctrl_wr_c = wr_c && (bus.addr == A_CTRL);
    push_c    = wr_c && (bus.addr == A_DATA);
    push_ok_c = push_c && (!full_c || pop_c);

    txen_d    = ctrl_wr_c ? bus.Data_in[0] : txen_q;
    intmsk_d  = ctrl_wr_c ? bus.Data_in[1] : intmsk_q;
    gray_d    = ctrl_wr_c ? bus.Data_in[4] : gray_q;
    intflag_d = set_int_c | (intflag_q & ~(ctrl_wr_c & bus.Data_in[2]));
    ovf_d     = (push_c & ~push_ok_c) | (ovf_q & ~(ctrl_wr_c & bus.Data_in[7]));
    div_d     = (wr_c && (bus.addr == A_DIV)) ? bus.Data_in : div_q;

    wptr_d  = push_ok_c ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = pop_c ? rptr_q + AW'(1) : rptr_q;
    count_d = count_q + CW'(push_ok_c) - CW'(pop_c);

    ready_d = bus.wr_en | bus.rd_en;
    dout_d  = dout_q;
    if (rd_c) begin
      case (bus.addr)
        A_CTRL:  dout_d = ctrl_c;
        A_DIV:   dout_d = div_q;
        A_LEVEL: dout_d = level_c;
        default: dout_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      state_q   <= IDLE;
      txen_q    <= 1'b0;
      intmsk_q  <= 1'b0;
      intflag_q <= 1'b0;
      gray_q    <= 1'b1;
      ovf_q     <= 1'b0;
      ready_q   <= 1'b0;
      div_q     <= 8'h00;
      cnt_q     <= 8'h00;
      dout_q    <= 8'h00;
      out_q     <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      txen_q    <= txen_d;
      intmsk_q  <= intmsk_d;
      intflag_q <= intflag_d;
      gray_q    <= gray_d;
      ovf_q     <= ovf_d;
      ready_q   <= ready_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      dout_q    <= dout_d;
      out_q     <= out_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
    end
  end

  // Storage is flushed by pointer reset, so the array itself carries no reset.
  always_ff @(posedge SYS_CLK) begin
    if (push_ok_c && !SYS_RST) mem_q[wptr_q] <= bus.Data_in[SYM_W-1:0];
  end

  assign OUT          = out_q;
  assign BSG_INT      = intflag_q & intmsk_q;
  assign bus.Data_out = dout_q;
  assign bus.ready    = ready_q;
endmodule

// File: tb/tb_bsg_fifo_tx.sv
// Directed bench for bsg_fifo_tx: register access, symbol timing, flags, overflow and reset abort.
module tb_bsg_fifo_tx;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] out_sym;
  logic       bsg_int;
  int         errors = 0;
  int         checks = 0;
  logic [7:0] rdata;
  logic       rrdy;
  logic [7:0] exp_seq [7];

  bsg_fifo_tx_if bus ();

  bsg_fifo_tx #(.DEPTH(8), .SYM_W(8)) dut (
    .SYS_CLK (clk),
    .SYS_RST (rst),
    .bus     (bus),
    .OUT     (out_sym),
    .BSG_INT (bsg_int)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.addr = a; bus.Data_in = d; bus.wr_en = 1'b1;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [7:0] d, output logic r);
    @(negedge clk);
    bus.addr = a; bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
    d = bus.Data_out;
    r = bus.ready;
  endtask

  initial begin
    bus.addr = 8'h00; bus.Data_in = 8'h00; bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // 1: reset state
    check("rst_out", out_sym, 8'h00);
    check("rst_int", {7'd0, bsg_int}, 8'h00);
    check("rst_ready", {7'd0, bus.ready}, 8'h00);
    bus_read(8'h00, rdata, rrdy);
    check("rst_ctrl", rdata, 8'h50);
    check("rst_ready_pulse", {7'd0, rrdy}, 8'h01);
    @(negedge clk);
    check("ready_one_cycle", {7'd0, bus.ready}, 8'h00);

    // 2: DIV=2, Gray, two symbols
    bus_write(8'h02, 8'h02);
    bus_write(8'h00, 8'h10);
    bus_write(8'h01, 8'h05);
    bus_write(8'h01, 8'h0A);
    bus_write(8'h00, 8'h11);
    check("t2_out_pre", out_sym, 8'h00);
    exp_seq = '{8'h07, 8'h07, 8'h07, 8'h0F, 8'h0F, 8'h0F, 8'h00};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check($sformatf("t2_out%0d", i), out_sym, exp_seq[i]);
    end
    bus_read(8'h00, rdata, rrdy);
    check("t2_ctrl_flag", rdata, 8'h55);
    check("t2_int_masked", {7'd0, bsg_int}, 8'h00);

    // 3: interrupt mask and W1C clear
    bus_write(8'h00, 8'h13);
    check("t3_int_on", {7'd0, bsg_int}, 8'h01);
    bus_write(8'h00, 8'h17);
    check("t3_int_off", {7'd0, bsg_int}, 8'h00);
    bus_read(8'h00, rdata, rrdy);
    check("t3_ctrl", rdata, 8'h53);

    // 4: overflow with TX disabled, then drain
    bus_write(8'h00, 8'h00);
    for (int i = 1; i <= 9; i++) bus_write(8'h01, 8'(i));
    bus_read(8'h03, rdata, rrdy);
    check("t4_level", rdata, 8'h08);
    bus_read(8'h00, rdata, rrdy);
    check("t4_ctrl_full_ovf", rdata, 8'hA0);
    bus_write(8'h00, 8'h80);
    bus_read(8'h00, rdata, rrdy);
    check("t4_ovf_clr", rdata, 8'h20);
    bus_write(8'h02, 8'h00);
    bus_write(8'h00, 8'h01);
    check("t4_out_pre", out_sym, 8'h00);
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      check($sformatf("t4_out%0d", i), out_sym, (i == 9) ? 8'h00 : 8'(i));
    end
    bus_read(8'h03, rdata, rrdy);
    check("t4_level_drained", rdata, 8'h00);
    bus_read(8'h00, rdata, rrdy);
    check("t4_ctrl_drained", rdata, 8'h45);

    // 5: binary, DIV=0, back-to-back with STATUS sampled mid-burst
    bus_write(8'h00, 8'h04);
    bus_write(8'h01, 8'hFF);
    bus_write(8'h01, 8'h00);
    bus_write(8'h01, 8'h81);
    bus_write(8'h00, 8'h01);
    check("t5_out_pre", out_sym, 8'h00);
    @(negedge clk);
    check("t5_out0", out_sym, 8'hFF);
    bus.addr = 8'h00; bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
    check("t5_out1", out_sym, 8'h00);
    check("t5_ctrl_busy", bus.Data_out, 8'h09);
    check("t5_ready", {7'd0, bus.ready}, 8'h01);
    @(negedge clk);
    check("t5_out2", out_sym, 8'h81);
    @(negedge clk);
    check("t5_out_idle", out_sym, 8'h00);

    // 6: reset mid-symbol with words still queued
    bus_write(8'h00, 8'h04);
    bus_write(8'h02, 8'h03);
    bus_write(8'h01, 8'h11);
    bus_write(8'h01, 8'h22);
    bus_write(8'h01, 8'h33);
    bus_write(8'h01, 8'h44);
    bus_write(8'h00, 8'h01);
    @(negedge clk);
    @(negedge clk);
    check("t6_out_mid", out_sym, 8'h11);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_out_rst", out_sym, 8'h00);
    bus_read(8'h03, rdata, rrdy);
    check("t6_level_rst", rdata, 8'h00);
    bus_read(8'h00, rdata, rrdy);
    check("t6_ctrl_rst", rdata, 8'h50);

    // 7: push into empty FIFO while enabled, plus unmapped reads
    bus_write(8'h00, 8'h01);
    bus_write(8'h01, 8'h3C);
    check("t7_out_wr", out_sym, 8'h00);
    @(negedge clk);
    check("t7_out_sym", out_sym, 8'h3C);
    @(negedge clk);
    check("t7_out_idle", out_sym, 8'h00);
    bus_read(8'h05, rdata, rrdy);
    check("t7_unmapped_data", rdata, 8'h00);
    check("t7_unmapped_ready", {7'd0, rrdy}, 8'h01);
    bus_read(8'h01, rdata, rrdy);
    check("t7_data_read", rdata, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
